gpio_debounce: RTL and testbench



---
 rtl/gpio_debounce.sv | 78 +++++++
 tb/tb_gpio_debounce.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin pad synchroniser, tick-based debouncer and rise/fall event generator
module gpio_debounce #(
  parameter int   WIDTH        = 8,
  parameter int   PRESCALE     = 1000,
  parameter int   STABLE_TICKS = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             event_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);
  logic [WIDTH-1:0]         s1_q, s2_q;
  logic [WIDTH-1:0]         pin_q, pin_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     event_q, event_d;
  logic [PW-1:0]            pre_q, pre_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic                     tick;
  // shared free-running prescaler; with PRESCALE=1 the tick is permanently high
  assign tick  = pre_q == PRE_MAX;
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  // per-pin stability window: any return to the accepted level restarts it
  always_comb begin
    pin_d  = pin_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == pin_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && cnt_q[i] == CNT_MAX) begin
        pin_d[i]  = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  // event is computed from the next-state pulses so it lands on the same edge
  assign event_d = |{rise_d, fall_d};
  // synchroniser, prescaler, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= {WIDTH{RESET_LEVEL}};
      s2_q    <= {WIDTH{RESET_LEVEL}};
      pin_q   <= {WIDTH{RESET_LEVEL}};
      pre_q   <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= 1'b0;
    end else begin
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      pin_q   <= pin_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end
  assign pin_o   = pin_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: three configurations checked cycle-by-cycle against a window-counting model
module tb_gpio_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  bit         go  = 1'b0;
  logic [7:0] pin_in  [3];
  logic [7:0] pin_out [3];
  logic [7:0] rise_out[3];
  logic [7:0] fall_out[3];
  logic       ev_out  [3];
  int         pr [3] = '{1, 5, 3};
  int         st [3] = '{4, 2, 3};
  bit         rl [3] = '{1'b0, 1'b0, 1'b1};
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_d1[3], m_d2[3], m_acc[3], m_rise[3], m_fall[3];
  logic       m_ev[3];
  int         m_e[3];
  int         m_start[3][8];
  logic [7:0] mr, mf;

  always #5 clk = ~clk;

  gpio_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .pin_i(pin_in[0]), .pin_o(pin_out[0]),
    .rise_o(rise_out[0]), .fall_o(fall_out[0]), .event_o(ev_out[0]));
  gpio_debounce #(.WIDTH(8), .PRESCALE(5), .STABLE_TICKS(2), .RESET_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .pin_i(pin_in[1]), .pin_o(pin_out[1]),
    .rise_o(rise_out[1]), .fall_o(fall_out[1]), .event_o(ev_out[1]));
  gpio_debounce #(.WIDTH(8), .PRESCALE(3), .STABLE_TICKS(3), .RESET_LEVEL(1'b1)) u_c (
    .clk(clk), .rst(rst), .pin_i(pin_in[2]), .pin_o(pin_out[2]),
    .rise_o(rise_out[2]), .fall_o(fall_out[2]), .event_o(ev_out[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge e (counted from reset release) is a tick when e mod P == P-1.
  // A level differing from the accepted one since edge d is accepted at the
  // first tick edge e where the ticks in [d, e] number STABLE_TICKS.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_d1[k]   = {8{rl[k]}};
        m_d2[k]   = {8{rl[k]}};
        m_acc[k]  = {8{rl[k]}};
        m_rise[k] = '0;
        m_fall[k] = '0;
        m_ev[k]   = 1'b0;
        m_e[k]    = 0;
        for (int b = 0; b < 8; b++) m_start[k][b] = -1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        mr = '0;
        mf = '0;
        for (int b = 0; b < 8; b++) begin
          if (m_d2[k][b] == m_acc[k][b]) m_start[k][b] = -1;
          else begin
            if (m_start[k][b] < 0) m_start[k][b] = m_e[k];
            if ((m_e[k] % pr[k] == pr[k] - 1) &&
                ((m_e[k] + 1) / pr[k] - m_start[k][b] / pr[k] == st[k])) begin
              m_acc[k][b]   = m_d2[k][b];
              mr[b]         = m_d2[k][b];
              mf[b]         = ~m_d2[k][b];
              m_start[k][b] = -1;
            end
          end
        end
        m_rise[k] = mr;
        m_fall[k] = mf;
        m_ev[k]   = |(mr | mf);
        m_d2[k]   = m_d1[k];
        m_d1[k]   = pin_in[k];
        m_e[k]++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (go) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("pin_o[%0d]", k), 32'(pin_out[k]), 32'(m_acc[k]));
        chk($sformatf("rise_o[%0d]", k), 32'(rise_out[k]), 32'(m_rise[k]));
        chk($sformatf("fall_o[%0d]", k), 32'(fall_out[k]), 32'(m_fall[k]));
        chk($sformatf("event_o[%0d]", k), 32'(ev_out[k]), 32'(m_ev[k]));
      end
    end
  end

  initial begin
    int n, cnt;
    logic tgt;
    pin_in[0] = 8'h00;
    pin_in[1] = 8'h00;
    pin_in[2] = 8'hFF;
    #1 rst = 1'b1;
    go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pin_in[0][0] = 1'b1;
    repeat (5) @(posedge clk);
    #2 chk("clean_e5_pin", 32'(pin_out[0]), 32'h00);
    chk("clean_e5_rise", 32'(rise_out[0]), 32'h00);
    @(posedge clk);
    #2 chk("clean_e6_pin", 32'(pin_out[0]), 32'h01);
    chk("clean_e6_rise", 32'(rise_out[0]), 32'h01);
    chk("clean_e6_ev", 32'(ev_out[0]), 32'h1);
    chk("rl1_pin", 32'(pin_out[2]), 32'hFF);
    chk("rl1_fall", 32'(fall_out[2]), 32'h00);
    @(posedge clk);
    #2 chk("clean_e7_rise", 32'(rise_out[0]), 32'h00);
    chk("clean_e7_ev", 32'(ev_out[0]), 32'h0);
    chk("clean_e7_pin", 32'(pin_out[0]), 32'h01);
    @(negedge clk);
    pin_in[0][3] = 1'b1;
    repeat (3) @(negedge clk);
    pin_in[0][3] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_pin", 32'(pin_out[0]), 32'h01);
    pin_in[0][3] = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rise_out[0][3]) cnt++;
    end
    chk("hold_rise_cnt", 32'(cnt), 32'd1);
    chk("hold_pin", 32'(pin_out[0]), 32'h09);
    for (int t = 0; t < 2; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      tgt = ~pin_in[1][0];
      pin_in[1][0] = tgt;
      n = 0;
      do begin
        @(posedge clk);
        #2 n++;
      end while (pin_out[1][0] !== tgt && n < 40);
      chk("pre_lat_ok", 32'((n - 2 >= 6) && (n - 2 <= 10)), 32'd1);
    end
    @(negedge clk);
    pin_in[1][1] = 1'b1;
    cnt = 0;
    repeat (4) @(negedge clk);
    pin_in[1][1] = 1'b0;
    @(negedge clk);
    pin_in[1][1] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rise_out[1][1]) cnt++;
    end
    chk("bounce_rise_cnt", 32'(cnt), 32'd1);
    pin_in[0] = 8'h00;
    repeat (20) @(negedge clk);
    pin_in[0] = 8'hA5;
    n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while (ev_out[0] !== 1'b1 && n < 20);
    chk("multi_rise", 32'(rise_out[0]), 32'hA5);
    chk("multi_rise_fall", 32'(fall_out[0]), 32'h00);
    @(posedge clk);
    #2 chk("multi_rise_ev_end", 32'(ev_out[0]), 32'h0);
    @(negedge clk);
    pin_in[0] = 8'h00;
    n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while (ev_out[0] !== 1'b1 && n < 20);
    chk("multi_fall", 32'(fall_out[0]), 32'hA5);
    chk("multi_fall_rise", 32'(rise_out[0]), 32'h00);
    @(posedge clk);
    #2 chk("multi_fall_ev_end", 32'(ev_out[0]), 32'h0);
    @(negedge clk);
    pin_in[0][1] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rstmid_pin", 32'(pin_out[0]), 32'h00);
    chk("rstmid_rise", 32'(rise_out[0]), 32'h00);
    chk("rstmid_fall", 32'(fall_out[0]), 32'h00);
    chk("rstmid_ev", 32'(ev_out[0]), 32'h0);
    chk("rstmid_c_pin", 32'(pin_out[2]), 32'hFF);
    pin_in[0][1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ev_out[0]) cnt++;
    end
    chk("rst_release_quiet", 32'(cnt), 32'd0);
    pin_in[0][1] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2 chk("rst_hi_e5_rise", 32'(rise_out[0]), 32'h00);
    @(posedge clk);
    #2 chk("rst_hi_e6_rise", 32'(rise_out[0]), 32'h02);
    @(negedge clk);
    pin_in[2] = 8'hFF;
    repeat (20) @(negedge clk);
    pin_in[2][7] = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while (ev_out[2] !== 1'b1 && n < 40);
    chk("rl1_drop_fall", 32'(fall_out[2]), 32'h80);
    chk("rl1_drop_pin", 32'(pin_out[2]), 32'h7F);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 15) == 0) pin_in[k][b] = ~pin_in[k][b];
      if ($urandom_range(0, 699) == 0) begin
        @(posedge clk);
        #3 rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
